// File: rtl/box_cmd_tx.sv
// Sends {target box, score} to the Arduino as five 4-bit nibbles over a
// 4-phase req/ack GPIO handshake, with per-phase timeout and XOR check nibble.
`timescale 1ns/1ps
module box_cmd_tx #(
  parameter int unsigned SETUP_CYCLES   = 50,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        send,
  input  logic [2:0]  target_box,
  input  logic [10:0] score,
  output logic        busy,
  output logic        done,
  output logic        timeout_err,
  output logic [3:0]  gpio_data,
  output logic        gpio_req,
  input  logic        gpio_ack
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_IDLE, S_SETUP, S_REQ_HI, S_REQ_LO
  } state_t;

  localparam logic [15:0] SETUP_LAST = 16'(SETUP_CYCLES - 1);
  localparam logic [19:0] TMO_LAST   = 20'(TIMEOUT_CYCLES - 1);

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [2:0]             idx_q, idx_d;
  logic [15:0]            setup_cnt_q, setup_cnt_d;
  logic [19:0]            tmo_cnt_q, tmo_cnt_d;
  logic [2:0]             box_q, box_d;
  logic [10:0]            score_q, score_d;
  logic [3:0]             data_q, data_d;
  logic                   req_q, req_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   terr_q, terr_d;
  logic                   ack_s;
  logic                   abort;
  logic                   tmo_hit;

  // Nibble 4 is the XOR of the first four so the peer can reject torn frames.
  function automatic logic [3:0] frame_nibble(input logic [2:0]  box,
                                              input logic [10:0] sc,
                                              input logic [2:0]  idx);
    logic [3:0] n0, n1, n2, n3;
    n0 = {1'b1, box};
    n1 = {1'b0, sc[10:8]};
    n2 = sc[7:4];
    n3 = sc[3:0];
    case (idx)
      3'd0:    return n0;
      3'd1:    return n1;
      3'd2:    return n2;
      3'd3:    return n3;
      default: return n0 ^ n1 ^ n2 ^ n3;
    endcase
  endfunction

  assign sync_d  = {sync_q[SYNC_STAGES-2:0], gpio_ack};
  assign ack_s   = sync_q[SYNC_STAGES-1];
  assign tmo_hit = (tmo_cnt_q == TMO_LAST);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    setup_cnt_d = setup_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    box_d       = box_q;
    score_d     = score_q;
    data_d      = data_q;
    req_d       = req_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    terr_d      = 1'b0;
    abort       = 1'b0;

    case (state_q)
      S_IDLE: begin
        req_d  = 1'b0;
        data_d = 4'd0;
        if (send) begin
          box_d     = target_box;
          score_d   = score;
          busy_d    = 1'b1;
          idx_d     = 3'd0;
          tmo_cnt_d = 20'd0;
          state_d   = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (!ack_s) begin
          idx_d       = 3'd0;
          setup_cnt_d = 16'd0;
          data_d      = frame_nibble(box_q, score_q, 3'd0);
          state_d     = S_SETUP;
        end else if (tmo_hit) begin
          abort = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 20'd1;
        end
      end
      S_SETUP: begin
        if (setup_cnt_q == SETUP_LAST) begin
          req_d     = 1'b1;
          tmo_cnt_d = 20'd0;
          state_d   = S_REQ_HI;
        end else begin
          setup_cnt_d = setup_cnt_q + 16'd1;
        end
      end
      S_REQ_HI: begin
        if (ack_s) begin
          req_d     = 1'b0;
          tmo_cnt_d = 20'd0;
          state_d   = S_REQ_LO;
        end else if (tmo_hit) begin
          abort = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 20'd1;
        end
      end
      S_REQ_LO: begin
        if (!ack_s) begin
          if (idx_q == 3'd4) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            data_d  = 4'd0;
            state_d = S_IDLE;
          end else begin
            idx_d       = idx_q + 3'd1;
            setup_cnt_d = 16'd0;
            data_d      = frame_nibble(box_q, score_q, idx_q + 3'd1);
            state_d     = S_SETUP;
          end
        end else if (tmo_hit) begin
          abort = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 20'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A stalled peer drops the whole frame; the bus is parked idle.
    if (abort) begin
      req_d   = 1'b0;
      data_d  = 4'd0;
      busy_d  = 1'b0;
      terr_d  = 1'b1;
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sync_q      <= '0;
      idx_q       <= 3'd0;
      setup_cnt_q <= 16'd0;
      tmo_cnt_q   <= 20'd0;
      data_q      <= 4'd0;
      req_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      terr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      idx_q       <= idx_d;
      setup_cnt_q <= setup_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      data_q      <= data_d;
      req_q       <= req_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      terr_q      <= terr_d;
    end
  end

  // Captured frame contents are only read after acceptance, so they need no reset.
  always_ff @(posedge CLOCK_50) begin
    box_q   <= box_d;
    score_q <= score_d;
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = terr_q;
  assign gpio_data   = data_q;
  assign gpio_req    = req_q;

endmodule

// File: tb/tb_box_cmd_tx.sv
// Bench for box_cmd_tx: responder model, per-cycle protocol monitor and a
// frame model derived from the nibble encoding rules.
`timescale 1ns/1ps
module tb_box_cmd_tx;
  localparam int SETUP = 4;
  localparam int TMO   = 100;
  localparam int SYNC  = 2;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic        send;
  logic [2:0]  target_box;
  logic [10:0] score;
  logic        busy, done, timeout_err;
  logic [3:0]  gpio_data;
  logic        gpio_req;
  logic        gpio_ack;

  int errors = 0;
  int checks = 0;

  box_cmd_tx #(
    .SETUP_CYCLES(SETUP), .TIMEOUT_CYCLES(TMO), .SYNC_STAGES(SYNC)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .send(send), .target_box(target_box),
    .score(score), .busy(busy), .done(done), .timeout_err(timeout_err),
    .gpio_data(gpio_data), .gpio_req(gpio_req), .gpio_ack(gpio_ack)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Frame as 5 nibbles packed MSB-first, from plain arithmetic on the inputs.
  function automatic logic [19:0] model_frame(input int box, input int sc);
    int n[5];
    n[0] = 8 + box;
    n[1] = sc / 256;
    n[2] = (sc / 16) % 16;
    n[3] = sc % 16;
    n[4] = n[0] ^ n[1] ^ n[2] ^ n[3];
    return {4'(n[0]), 4'(n[1]), 4'(n[2]), 4'(n[3]), 4'(n[4])};
  endfunction

  // Responder: mode 0 follows req after 3 cycles, mode 1 drives resp_level.
  int   resp_mode  = 0;
  logic resp_level = 1'b0;
  initial begin
    int dly;
    dly = 0;
    gpio_ack = 1'b0;
    forever begin
      @(negedge CLOCK_50);
      if (resp_mode == 0) begin
        if (gpio_req != gpio_ack) begin
          dly++;
          if (dly >= 3) begin
            gpio_ack = gpio_req;
            dly = 0;
          end
        end else dly = 0;
      end else begin
        gpio_ack = resp_level;
        dly = 0;
      end
    end
  end

  // Protocol monitor
  logic [3:0] got[$];
  int   done_cnt = 0, terr_cnt = 0, req_len = 0, last_req_len = 0, run_len = 0;
  logic prev_req = 1'b0, prev_done = 1'b0, prev_terr = 1'b0;
  logic [3:0] prev_data = 4'd0;

  always @(negedge CLOCK_50) begin
    run_len = (gpio_data == prev_data) ? run_len + 1 : 1;
    if (gpio_req && !prev_req) begin
      got.push_back(gpio_data);
      check("setup_stable", int'(run_len - 1 >= SETUP), 1);
    end
    if (gpio_req && prev_req) check("data_hold_under_req", gpio_data, prev_data);
    if (gpio_req) req_len++;
    else if (prev_req) begin
      last_req_len = req_len;
      req_len = 0;
    end
    if (done || timeout_err) check("done_terr_exclusive", int'(done && timeout_err), 0);
    if (done) begin
      done_cnt++;
      check("busy_low_at_done", busy, 0);
      check("done_single_cycle", prev_done, 0);
    end
    if (timeout_err) begin
      terr_cnt++;
      check("abort_outputs", {busy, gpio_req, gpio_data}, 0);
      check("terr_single_cycle", prev_terr, 0);
    end
    if (!busy) check("idle_outputs", {gpio_req, gpio_data}, 0);
    prev_req  = gpio_req;
    prev_data = gpio_data;
    prev_done = done;
    prev_terr = timeout_err;
  end

  task automatic start_frame(input int box, input int sc);
    @(negedge CLOCK_50);
    target_box = 3'(box);
    score      = 11'(sc);
    send       = 1'b1;
    @(negedge CLOCK_50);
    send = 1'b0;
  endtask

  // kind: 0 = budget expired, 1 = done, 2 = timeout_err
  task automatic wait_end(input int budget, output int kind, output int cycles);
    kind = 0;
    cycles = 0;
    while (kind == 0 && cycles < budget) begin
      @(negedge CLOCK_50);
      cycles++;
      if (done) kind = 1;
      else if (timeout_err) kind = 2;
    end
  endtask

  task automatic cmp_nibs(input string tag, input int start, input logic [19:0] exp);
    for (int i = 0; i < 5; i++) begin
      int a;
      a = (start + i < got.size()) ? int'(got[start + i]) : -1;
      check($sformatf("%s_nib%0d", tag, i), a, int'(exp[19 - 4*i -: 4]));
    end
  endtask

  task automatic run_frame(input string tag, input int box, input int sc);
    int kind, cyc, d0;
    got.delete();
    d0 = done_cnt;
    start_frame(box, sc);
    wait_end(400, kind, cyc);
    @(negedge CLOCK_50);
    check({tag, "_end"}, kind, 1);
    check({tag, "_count"}, got.size(), 5);
    cmp_nibs(tag, 0, model_frame(box, sc));
    check({tag, "_done_cnt"}, done_cnt - d0, 1);
    check({tag, "_busy_after"}, busy, 0);
  endtask

  initial begin
    int kind, cyc, d0, t0;
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, cyc, d0, t0;
    reset = 1'b0;
    send = 1'b0;
    target_box = 3'd0;
    score = 11'd0;
    #1 reset = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_terr", timeout_err, 0);
    check("rst_req", gpio_req, 0);
    check("rst_data", gpio_data, 0);
    reset = 1'b0;

    // Hand-computed frames pin the model.
    check("model_pin_a", model_frame(5, 'h2A7), 'hD2A72);
    check("model_pin_b", model_frame(0, 0), 'h80008);
    check("model_pin_c", model_frame(7, 'h7FF), 'hF7FF8);
    check("model_pin_d", model_frame(3, 1), 'hB001A);

    repeat (4) @(negedge CLOCK_50);
    run_frame("basic", 5, 'h2A7);
    run_frame("zero", 0, 0);
    run_frame("max", 7, 'h7FF);

    // Silent peer while req is high.
    resp_mode = 1;
    resp_level = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    got.delete();
    d0 = done_cnt;
    t0 = terr_cnt;
    start_frame(2, 'h155);
    wait_end(400, kind, cyc);
    @(negedge CLOCK_50);
    check("tmo_kind", kind, 2);
    check("tmo_req_len", last_req_len, TMO);
    check("tmo_terr_cnt", terr_cnt - t0, 1);
    check("tmo_no_done", done_cnt - d0, 0);
    check("tmo_nibs_sent", got.size(), 1);
    check("tmo_data_zero", gpio_data, 0);
    resp_mode = 0;
    run_frame("after_tmo", 2, 'h155);

    // send held high across a frame, inputs changed mid-frame.
    got.delete();
    d0 = done_cnt;
    @(negedge CLOCK_50);
    target_box = 3'd1;
    score = 11'h123;
    send = 1'b1;
    for (int i = 0; i < 400 && got.size() < 2; i++) @(negedge CLOCK_50);
    check("rej_mid_reached", int'(got.size() >= 2), 1);
    target_box = 3'd6;
    score = 11'h456;
    for (int i = 0; i < 400 && !done; i++) @(negedge CLOCK_50);
    check("rej_first_done", done, 1);
    check("rej_first_count", got.size(), 5);
    cmp_nibs("rej_first", 0, model_frame(1, 'h123));
    @(negedge CLOCK_50);
    check("rej_refire_busy", busy, 1);
    send = 1'b0;
    wait_end(400, kind, cyc);
    @(negedge CLOCK_50);
    check("rej_second_end", kind, 1);
    check("rej_total_count", got.size(), 10);
    cmp_nibs("rej_second", 5, model_frame(6, 'h456));
    check("rej_done_cnt", done_cnt - d0, 2);

    // Peer stuck busy, then releases.
    resp_mode = 1;
    resp_level = 1'b1;
    repeat (5) @(negedge CLOCK_50);
    got.delete();
    start_frame(4, 'h0AA);
    for (int i = 0; i < 19; i++) begin
      @(negedge CLOCK_50);
      check("stuck_req_low", gpio_req, 0);
    end
    check("stuck_busy", busy, 1);
    resp_level = 1'b0;
    @(negedge CLOCK_50);
    resp_mode = 0;
    wait_end(400, kind, cyc);
    @(negedge CLOCK_50);
    check("stuck_end", kind, 1);
    check("stuck_count", got.size(), 5);
    cmp_nibs("stuck", 0, model_frame(4, 'h0AA));

    // Peer stuck busy for the whole timeout.
    resp_mode = 1;
    resp_level = 1'b1;
    repeat (5) @(negedge CLOCK_50);
    got.delete();
    start_frame(4, 'h0AA);
    wait_end(400, kind, cyc);
    @(negedge CLOCK_50);
    check("stuck_tmo_kind", kind, 2);
    check("stuck_tmo_latency", cyc, TMO);
    check("stuck_tmo_no_req", got.size(), 0);
    resp_mode = 0;
    repeat (8) @(negedge CLOCK_50);

    // Asynchronous reset during REQ_HI of nibble 2.
    got.delete();
    start_frame(5, 'h2A7);
    for (int i = 0; i < 400 && !(got.size() >= 3 && gpio_req); i++) @(negedge CLOCK_50);
    check("rst_mid_reached", int'(got.size() >= 3 && gpio_req), 1);
    #3 reset = 1'b1;
    #1;
    check("rst_mid_req", gpio_req, 0);
    check("rst_mid_data", gpio_data, 0);
    check("rst_mid_busy", busy, 0);
    repeat (3) @(negedge CLOCK_50);
    reset = 1'b0;
    run_frame("post_reset", 3, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
